wbu_gpr_writeback: RTL
======================

Name: wbu_gpr_writeback

Overview:
- Write-back front end that drives the single write port of the RV64IM GPR file (write enable, destination index, write data).
- Arbitrates each cycle between two result sources: the in-order pipeline result (ALU/LSU) and the long-latency multiply/divide unit (MDU).
- Keeps a busy scoreboard of registers with outstanding MDU results.
- Provides same-cycle write-to-read bypass for the two IDU read ports.

Parameters:
- XLEN, 64, data width of GPR and result buses.
- GPR_NUM, 32, number of architectural registers.
- GPR_W, 5, register index width; must equal log2(GPR_NUM).

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- pipe_valid  in  1  pipeline result valid.
- pipe_ready  out  1  pipeline result accepted this cycle when high together with pipe_valid.
- pipe_wen  in  1  pipeline result writes a GPR; 0 means the instruction retires with no write.
- pipe_rd  in  GPR_W  pipeline destination register.
- pipe_data  in  XLEN  pipeline result data.
- mdu_issue  in  1  MDU operation issued this cycle.
- mdu_issue_rd  in  GPR_W  destination register of the issued MDU operation.
- mdu_valid  in  1  MDU result valid; held stable until accepted.
- mdu_ready  out  1  MDU result accepted.
- mdu_rd  in  GPR_W  MDU destination register.
- mdu_data  in  XLEN  MDU result data.
- RegWr  out  1  GPR write enable.
- WBU_rd  out  GPR_W  GPR write index.
- rf_busW  out  XLEN  GPR write data.
- busy_mask  out  GPR_NUM  bit i set means an MDU result to register i is outstanding.
- IDU_rs1, IDU_rs2  in  GPR_W  IDU read indices.
- gpr_rs1_data, gpr_rs2_data  in  XLEN  raw GPR file read data.
- IDU_rs1_data, IDU_rs2_data  out  XLEN  bypassed read data.

Behaviour:
- Reset:
  - RegWr=0, WBU_rd=0, rf_busW=0, busy_mask=0.
  - pipe_ready=0 and mdu_ready=0 while rst is high.
  - Reset asserted mid-operation discards any pending write and clears all busy bits.
- Arbitration (combinational):
  - mdu_ready = !rst.
  - pipe_ready = !rst & !mdu_valid.
  - MDU has strict priority; the pipeline stalls while an MDU result is waiting.
  - At most one result is accepted per cycle.
- Write register stage:
  - A transfer accepted at edge N drives RegWr/WBU_rd/rf_busW for the cycle after edge N.
  - The GPR file is updated at edge N+1.
  - One-cycle latency; no back-pressure from the GPR file.
  - RegWr = 1 only if the accepted result writes (MDU always writes; pipeline writes only when pipe_wen=1) and the destination rd is not 0.
  - Otherwise RegWr=0, and WBU_rd/rf_busW still load the accepted values.
  - Cycle with no accepted transfer: RegWr=0; WBU_rd and rf_busW hold their previous values.
- Scoreboard:
  - mdu_issue with mdu_issue_rd not 0 sets the matching busy bit at the next edge.
  - Accepting an MDU result clears busy[mdu_rd] at the same edge.
  - Set and clear of the same index in the same cycle: set wins.
  - Issue to register 0 is ignored; busy_mask[0] is always 0.
  - Pipeline writes never change busy bits. Write-after-write ordering is the issue logic's responsibility; the write is still performed.
- Bypass (combinational):
  - IDU_rsK_data = rf_busW when RegWr=1, WBU_rd==IDU_rsK, and IDU_rsK is not 0.
  - Otherwise IDU_rsK_data = gpr_rsK_data.
  - Register 0 always reads the raw data.
- Handshake rules:
  - When an input valid is high and the matching ready is low, the source must hold rd/data stable.
  - The block never accepts a transfer while its valid is low.

Test Plan:
- Reset: assert rst with pipe_valid=1 and mdu_valid=1 -> pipe_ready=0, mdu_ready=0, RegWr=0, busy_mask=0. Release rst -> MDU result accepted first.
- Pipeline write: pipe_valid=1, pipe_wen=1, pipe_rd=5, pipe_data=0xDEADBEEF_00000001 -> next cycle RegWr=1, WBU_rd=5, rf_busW equals that data. With IDU_rs1=5 in that cycle, IDU_rs1_data=0xDEADBEEF_00000001 regardless of gpr_rs1_data.
- rd=0 suppression: pipeline write to rd=0 with data 0x1234 -> RegWr=0. mdu_issue to rd=0 -> busy_mask unchanged.
- Priority: pipe_valid and mdu_valid both high, mdu_rd=7, pipe_rd=8 -> MDU accepted first with pipe_ready=0; pipeline accepted the next cycle. Writes appear in order rd 7 then rd 8 on consecutive cycles.
- Scoreboard: issue to rd=10 -> busy_mask[10]=1. MDU result rd=10 accepted in the same cycle as a new issue to rd=10 -> busy_mask[10] stays 1. Then a result with no new issue -> busy_mask[10]=0.
- Reset mid-operation: busy_mask=0x00000400 and an accepted write pending, assert rst one cycle -> RegWr=0 and busy_mask=0 after the edge.

Source files
------------

// File: rtl/wbu_gpr_writeback_if.sv
// Result-source bundle for the write-back unit: the in-order pipeline
// result channel, the MDU result channel and the MDU issue notification.
// The master side belongs to the producers; the slave side belongs to the WBU.
interface wbu_gpr_writeback_if #(
    parameter int XLEN  = 64,
    parameter int GPR_W = 5
);
    // Pipeline (ALU/LSU) result channel
    logic             pipe_valid;
    logic             pipe_ready;
    logic             pipe_wen;
    logic [GPR_W-1:0] pipe_rd;
    logic [XLEN-1:0]  pipe_data;

    // MDU issue notification, which feeds the busy scoreboard
    logic             mdu_issue;
    logic [GPR_W-1:0] mdu_issue_rd;

    // MDU result channel
    logic             mdu_valid;
    logic             mdu_ready;
    logic [GPR_W-1:0] mdu_rd;
    logic [XLEN-1:0]  mdu_data;

    modport master (
        output pipe_valid, pipe_wen, pipe_rd, pipe_data,
        output mdu_issue, mdu_issue_rd,
        output mdu_valid, mdu_rd, mdu_data,
        input  pipe_ready, mdu_ready
    );

    modport slave (
        input  pipe_valid, pipe_wen, pipe_rd, pipe_data,
        input  mdu_issue, mdu_issue_rd,
        input  mdu_valid, mdu_rd, mdu_data,
        output pipe_ready, mdu_ready
    );
endinterface

// File: rtl/wbu_gpr_writeback.sv
// Write-back front end for the RV64IM GPR file. It drives the single GPR
// write port from either the pipeline or the MDU (the MDU has strict
// priority), tracks registers with outstanding MDU results, and forwards
// the write currently on the port to the two IDU read ports.
module wbu_gpr_writeback #(
    parameter int XLEN    = 64,
    parameter int GPR_NUM = 32,
    parameter int GPR_W   = 5    // must equal log2(GPR_NUM)
) (
    input  logic               clk,
    input  logic               rst,
    wbu_gpr_writeback_if.slave res,

    // GPR file write port
    output logic               RegWr,
    output logic [GPR_W-1:0]   WBU_rd,
    output logic [XLEN-1:0]    rf_busW,

    // Registers waiting on an MDU result
    output logic [GPR_NUM-1:0] busy_mask,

    // IDU read ports with write-to-read bypass
    input  logic [GPR_W-1:0]   IDU_rs1,
    input  logic [GPR_W-1:0]   IDU_rs2,
    input  logic [XLEN-1:0]    gpr_rs1_data,
    input  logic [XLEN-1:0]    gpr_rs2_data,
    output logic [XLEN-1:0]    IDU_rs1_data,
    output logic [XLEN-1:0]    IDU_rs2_data
);

    logic               mdu_fire;
    logic               pipe_fire;
    logic [GPR_NUM-1:0] busy_next;

    // Arbitration: MDU always wins, the pipeline stalls while an MDU result waits.
    always_comb begin
        res.mdu_ready  = !rst;
        res.pipe_ready = !rst && !res.mdu_valid;
        mdu_fire       = res.mdu_valid  && res.mdu_ready;
        pipe_fire      = res.pipe_valid && res.pipe_ready;
    end

    // Write register stage: one accepted result drives the GPR write port next cycle.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            RegWr   <= 1'b0;
            WBU_rd  <= '0;
            rf_busW <= '0;
        end else if (mdu_fire) begin
            RegWr   <= (res.mdu_rd != '0);
            WBU_rd  <= res.mdu_rd;
            rf_busW <= res.mdu_data;
        end else if (pipe_fire) begin
            RegWr   <= res.pipe_wen && (res.pipe_rd != '0);
            WBU_rd  <= res.pipe_rd;
            rf_busW <= res.pipe_data;
        end else begin
            // No transfer: index and data hold, only the enable drops.
            RegWr   <= 1'b0;
        end
    end

    // Scoreboard next state: clear on MDU result, then set on issue so set wins.
    always_comb begin
        // NOTE: default first so every path assigns busy_next and no latch is inferred.
        busy_next = busy_mask;
        if (mdu_fire) begin
            busy_next[res.mdu_rd] = 1'b0;
        end
        if (res.mdu_issue && (res.mdu_issue_rd != '0)) begin
            busy_next[res.mdu_issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Scoreboard register; reset discards all outstanding MDU results.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_mask <= '0;
        end else begin
            busy_mask <= busy_next;
        end
    end

    // Bypass: the write on the port this cycle is visible to the IDU reads; x0 never bypasses.
    always_comb begin
        IDU_rs1_data = gpr_rs1_data;
        IDU_rs2_data = gpr_rs2_data;
        if (RegWr && (WBU_rd == IDU_rs1) && (IDU_rs1 != '0)) begin
            IDU_rs1_data = rf_busW;
        end
        if (RegWr && (WBU_rd == IDU_rs2) && (IDU_rs2 != '0)) begin
            IDU_rs2_data = rf_busW;
        end
    end

endmodule
